// File: rtl/dmm_pkg.sv
// Shared types and helpers for the data memory manager.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dmm_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RMW_WR = 2'd1,
        DONE   = 2'd2
    } dmm_state_t;

    // Byte offsets inside the memory-mapped register window
    localparam logic [31:0] DMM_LED_OFS = 32'h0000_0000;
    localparam logic [31:0] DMM_CNT_OFS = 32'h0000_0004;

    // Replace one little-endian byte lane of a word
    function automatic logic [31:0] dmm_merge_byte(input logic [31:0] word,
                                                   input logic [1:0]  lane,
                                                   input logic [7:0]  data);
        logic [31:0] merged;
        merged = word;
        case (lane)
            2'd0:    merged[7:0]   = data;
            2'd1:    merged[15:8]  = data;
            2'd2:    merged[23:16] = data;
            default: merged[31:24] = data;
        endcase
        return merged;
    endfunction

endpackage

// File: rtl/dmm_mmio_regs.sv
// MMIO register block: LED register, free-running cycle counter, read mux.
// Latency: writes take effect next cycle; read mux is combinational.
// Backpressure: none, always accepts.
module dmm_mmio_regs
    import dmm_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        i_led_we,
    input  logic [7:0]  i_led_wdata,
    input  logic [31:0] i_ofs,
    output logic [31:0] o_rdata,
    output logic [7:0]  o_leds
);

    logic [7:0]  r_leds;
    logic [31:0] r_cnt;

    // LED register write and counter increment (wraps naturally)
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_leds <= 8'h00;
            r_cnt  <= 32'h0;
        end else begin
            r_cnt <= r_cnt + 32'd1;
            if (i_led_we) begin
                r_leds <= i_led_wdata;
            end
        end
    end

    // Read mux; unmapped offsets read as zero
    always_comb begin
        o_rdata = 32'h0;
        if (i_ofs == DMM_LED_OFS) begin
            o_rdata = {24'h0, r_leds};
        end else if (i_ofs == DMM_CNT_OFS) begin
            o_rdata = r_cnt;
        end
    end

    assign o_leds = r_leds;

endmodule

// File: rtl/data_mem_manager.sv
// Data memory manager: CPU word/byte loads and stores onto a word-wide sync RAM (MMIO window under DMM_MMIO_EN).
// Latency: loads return 1 cycle after issue; word stores write same cycle; byte stores take a 2-cycle RMW.
// Backpressure: stall_o holds the CPU during the RMW read and write cycles; no other stalls.
module data_mem_manager
    import dmm_pkg::*;
#(
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] MMIO_BASE = 32'h0000_F000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [31:0]       addr_i,
    input  logic [31:0]       wdata_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic              byte_mode_i,
    output logic [31:0]       rdata_o,
    output logic              rvalid_o,
    output logic              stall_o,
    output logic              err_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [31:0]       ram_wdata_o,
    output logic              ram_we_o,
    input  logic [31:0]       ram_rdata_i,
    output logic [7:0]        leds_o
);

    dmm_state_t        r_state;
    dmm_state_t        w_state_nxt;
    logic [ADDR_W-1:0] r_idx;
    logic [1:0]        r_lane;
    logic [7:0]        r_byte;
    logic              r_ld_pend;
    logic              r_ld_byte;
    logic              r_ld_mmio;
    logic [1:0]        r_ld_lane;
    logic [31:0]       r_mmio_rdata;
    logic              r_err;

    logic [ADDR_W-1:0] w_idx;
    logic [1:0]        w_lane;
    logic              w_idle;
    logic              w_req_st;
    logic              w_req_ld;
    logic              w_misalign;
    logic              w_rmw_start;
    logic              w_is_mmio;
    logic              w_mmio_bad_wr;
    logic [31:0]       w_mmio_rdata;
    logic              w_err_set;
    logic [31:0]       w_ld_word;
    logic [31:0]       w_ld_shift;

    assign w_idx  = addr_i[ADDR_W+1:2];
    assign w_lane = addr_i[1:0];
    assign w_idle = (r_state == IDLE);

    // Requests are only taken in IDLE; a store wins when both strobes are high
    assign w_req_st    = w_idle & we_i;
    assign w_req_ld    = w_idle & re_i & ~we_i;
    assign w_misalign  = ~byte_mode_i & (w_lane != 2'd0);
    assign w_rmw_start = w_req_st & byte_mode_i & ~w_is_mmio;

`ifdef DMM_MMIO_EN
    logic [31:0] w_ofs;
    logic        w_led_we;

    assign w_is_mmio     = (addr_i >= MMIO_BASE);
    assign w_ofs         = addr_i - MMIO_BASE;
    assign w_led_we      = w_req_st & w_is_mmio & (w_ofs == DMM_LED_OFS);
    assign w_mmio_bad_wr = w_req_st & w_is_mmio & (w_ofs != DMM_LED_OFS);

    dmm_mmio_regs u_mmio_regs (
        .CLK         (CLK),
        .RST         (RST),
        .i_led_we    (w_led_we),
        .i_led_wdata (wdata_i[7:0]),
        .i_ofs       (w_ofs),
        .o_rdata     (w_mmio_rdata),
        .o_leds      (leds_o)
    );
`else
    logic w_unused;

    assign w_is_mmio     = 1'b0;
    assign w_mmio_bad_wr = 1'b0;
    assign w_mmio_rdata  = 32'h0;
    assign leds_o        = 8'h00;
    assign w_unused      = ^{addr_i[31:ADDR_W+2], MMIO_BASE};
`endif

    assign w_err_set = (w_idle & (we_i | re_i) & w_misalign)
                     | (w_idle & we_i & re_i)
                     | w_mmio_bad_wr;

    // State register, load tracking, RMW capture and sticky error
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_lane       <= 2'd0;
            r_byte       <= 8'h00;
            r_ld_pend    <= 1'b0;
            r_ld_byte    <= 1'b0;
            r_ld_mmio    <= 1'b0;
            r_ld_lane    <= 2'd0;
            r_mmio_rdata <= 32'h0;
            r_err        <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ld_pend <= w_req_ld;
            if (w_req_ld) begin
                r_ld_byte    <= byte_mode_i;
                r_ld_lane    <= w_lane;
                r_ld_mmio    <= w_is_mmio;
                r_mmio_rdata <= w_mmio_rdata;
            end
            if (w_rmw_start) begin
                r_idx  <= w_idx;
                r_lane <= w_lane;
                r_byte <= wdata_i[7:0];
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    // Next state and RAM port drive; reset forces every output low at once
    always_comb begin
        w_state_nxt = r_state;
        stall_o     = 1'b0;
        ram_we_o    = 1'b0;
        ram_addr_o  = '0;
        ram_wdata_o = 32'h0;
        case (r_state)
            IDLE: begin
                if (w_req_st && !w_is_mmio) begin
                    ram_addr_o = w_idx;
                    if (byte_mode_i) begin
                        stall_o     = 1'b1;
                        w_state_nxt = RMW_WR;
                    end else begin
                        ram_we_o    = 1'b1;
                        ram_wdata_o = wdata_i;
                    end
                end else if (w_req_ld && !w_is_mmio) begin
                    ram_addr_o = w_idx;
                end
            end
            RMW_WR: begin
                stall_o     = 1'b1;
                ram_we_o    = 1'b1;
                ram_addr_o  = r_idx;
                ram_wdata_o = dmm_merge_byte(ram_rdata_i, r_lane, r_byte);
                w_state_nxt = DONE;
            end
            DONE: begin
                // CPU is still presenting the finished store; drop it
                ram_addr_o  = r_idx;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        if (!RST) begin
            stall_o     = 1'b0;
            ram_we_o    = 1'b0;
            ram_addr_o  = '0;
            ram_wdata_o = 32'h0;
        end
    end

    assign w_ld_word  = r_ld_mmio ? r_mmio_rdata : ram_rdata_i;
    assign w_ld_shift = w_ld_word >> {r_ld_lane, 3'b000};

    // Load return path, one cycle after the accepted load
    always_comb begin
        rdata_o = 32'h0;
        if (r_ld_pend) begin
            rdata_o = r_ld_byte ? {24'h0, w_ld_shift[7:0]} : w_ld_word;
        end
    end

    assign rvalid_o = r_ld_pend;
    assign err_o    = r_err;

endmodule

// File: tb/tb_data_mem_manager.sv
// Self-checking bench for data_mem_manager with a behavioural sync RAM.
// Latency: loads scored one cycle after issue via a queue.
// Backpressure: requests are held while stall_o is high and through the DONE cycle.
module tb_data_mem_manager;

    logic        CLK;
    logic        RST;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        we_i;
    logic        re_i;
    logic        byte_mode_i;
    logic [31:0] rdata_o;
    logic        rvalid_o;
    logic        stall_o;
    logic        err_o;
    logic [9:0]  ram_addr_o;
    logic [31:0] ram_wdata_o;
    logic        ram_we_o;
    logic [31:0] ram_rdata_i;
    logic [7:0]  leds_o;

    data_mem_manager #(.ADDR_W(10), .MMIO_BASE(32'h0000_F000)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .we_i        (we_i),
        .re_i        (re_i),
        .byte_mode_i (byte_mode_i),
        .rdata_o     (rdata_o),
        .rvalid_o    (rvalid_o),
        .stall_o     (stall_o),
        .err_o       (err_o),
        .ram_addr_o  (ram_addr_o),
        .ram_wdata_o (ram_wdata_o),
        .ram_we_o    (ram_we_o),
        .ram_rdata_i (ram_rdata_i),
        .leds_o      (leds_o)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural synchronous single-port RAM, read-before-write
    logic [31:0] mem [0:1023];
    always @(posedge CLK) begin
        if (ram_we_o) mem[ram_addr_o] <= ram_wdata_o;
        ram_rdata_i <= mem[ram_addr_o];
    end

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [9:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t         wr_q[$];
    logic [31:0] rd_q[$];
    logic        sb_skip = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        tests++;
        fails++;
        $display("FAIL %s: unexpected event, value %h, expected none", name, act);
    endtask

    // Scoreboard: RAM writes and load returns are popped as they appear
    always @(negedge CLK) begin
        if (RST === 1'b1) begin
            if (ram_we_o === 1'b1) begin
                if (wr_q.size() == 0) begin
                    unexpected("ram_write", {22'h0, ram_addr_o});
                end else begin
                    wr_t e;
                    e = wr_q.pop_front();
                    chk("ram_waddr", {22'h0, ram_addr_o}, {22'h0, e.a});
                    chk("ram_wdata", ram_wdata_o, e.d);
                end
            end
            if (rvalid_o === 1'b1 && !sb_skip) begin
                if (rd_q.size() == 0) begin
                    unexpected("rvalid", rdata_o);
                end else begin
                    logic [31:0] exp_d;
                    exp_d = rd_q.pop_front();
                    chk("rdata", rdata_o, exp_d);
                end
            end
        end
    end

    // Present one request, hold it through any stall and the DONE cycle
    task automatic do_req(input logic we, input logic re, input logic bm,
                          input logic [31:0] a, input logic [31:0] d,
                          output int stalls);
        we_i = we; re_i = re; byte_mode_i = bm; addr_i = a; wdata_i = d;
        stalls = 0;
        #1;
        while (stall_o === 1'b1 && stalls < 8) begin
            @(posedge CLK); #1;
            stalls++;
        end
        @(posedge CLK); #1;
        we_i = 1'b0; re_i = 1'b0; byte_mode_i = 1'b0; addr_i = 32'h0; wdata_i = 32'h0;
    endtask

    typedef struct {
        logic        we;
        logic        re;
        logic        bm;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_wr;
        logic [9:0]  exp_waddr;
        logic [31:0] exp_wdata;
        logic        exp_ld;
        logic [31:0] exp_rdata;
        int          exp_stalls;
        logic        exp_err;
    } vec_t;

    vec_t vecs[16];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;

        //         we    re    bm    addr          wdata         wr    waddr  wdata         ld    rdata         st  err
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 10'd4, 32'hDEAD_BEEF, 1'b0, 32'h0,         0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 10'd0, 32'h0,         1'b1, 32'hDEAD_BEEF, 0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h1122_3344, 1'b1, 10'd4, 32'h1122_3344, 1'b0, 32'h0,         0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 32'h0000_0012, 32'hFFFF_FFAA, 1'b1, 10'd4, 32'h11AA_3344, 1'b0, 32'h0,         2, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 32'h0000_0013, 32'h0,         1'b0, 10'd0, 32'h0,         1'b1, 32'h0000_0011, 0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 32'h0000_0012, 32'h0,         1'b0, 10'd0, 32'h0,         1'b1, 32'h0000_00AA, 0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 32'h0000_0010, 32'h0,         1'b0, 10'd0, 32'h0,         1'b1, 32'h0000_0044, 0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 10'd0, 32'h0,         1'b1, 32'h11AA_3344, 0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 32'h0000_1008, 32'h1234_5678, 1'b1, 10'd2, 32'h1234_5678, 1'b0, 32'h0,         0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0008, 32'h0,         1'b0, 10'd0, 32'h0,         1'b1, 32'h1234_5678, 0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 32'h0000_000B, 32'h0000_0099, 1'b1, 10'd2, 32'h9934_5678, 1'b0, 32'h0,         2, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 32'h0000_0008, 32'h0,         1'b0, 10'd0, 32'h0,         1'b1, 32'h9934_5678, 0, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 32'h0000_0004, 32'hCAFE_F00D, 1'b1, 10'd1, 32'hCAFE_F00D, 1'b0, 32'h0,         0, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 32'h0000_0006, 32'h0,         1'b0, 10'd0, 32'h0,         1'b1, 32'hCAFE_F00D, 0, 1'b1};
        vecs[14] = '{1'b1, 1'b1, 1'b0, 32'h0000_0014, 32'h0BAD_BEEF, 1'b1, 10'd5, 32'h0BAD_BEEF, 1'b0, 32'h0,         0, 1'b1};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 32'h0000_0014, 32'h0,         1'b0, 10'd0, 32'h0,         1'b1, 32'h0BAD_BEEF, 0, 1'b1};

        // Reset state, with a word store presented to show outputs are held low
        RST = 1'b0;
        we_i = 1'b1; re_i = 1'b0; byte_mode_i = 1'b0; addr_i = 32'h10; wdata_i = 32'h1234_5678;
        #3;
        chk("reset rdata_o", rdata_o, 32'h0);
        chk("reset rvalid_o", {31'h0, rvalid_o}, 32'h0);
        chk("reset stall_o", {31'h0, stall_o}, 32'h0);
        chk("reset err_o", {31'h0, err_o}, 32'h0);
        chk("reset ram_we_o", {31'h0, ram_we_o}, 32'h0);
        chk("reset ram_addr_o", {22'h0, ram_addr_o}, 32'h0);
        chk("reset ram_wdata_o", ram_wdata_o, 32'h0);
        chk("reset leds_o", {24'h0, leds_o}, 32'h0);
        we_i = 1'b0; addr_i = 32'h0; wdata_i = 32'h0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK); #1;

        // Table-driven main function
        for (int i = 0; i < 16; i++) begin
            if (vecs[i].exp_wr) wr_q.push_back('{vecs[i].exp_waddr, vecs[i].exp_wdata});
            if (vecs[i].exp_ld) rd_q.push_back(vecs[i].exp_rdata);
            do_req(vecs[i].we, vecs[i].re, vecs[i].bm, vecs[i].addr, vecs[i].wdata, st);
            chk($sformatf("vec%0d stall cycles", i), st, vecs[i].exp_stalls);
            chk($sformatf("vec%0d err_o", i), {31'h0, err_o}, {31'h0, vecs[i].exp_err});
        end
        @(posedge CLK); #1;

        // Reset asserted during RMW_WR abandons the write
        we_i = 1'b1; re_i = 1'b0; byte_mode_i = 1'b1; addr_i = 32'h20; wdata_i = 32'h77;
        #1;
        chk("rmw T stall_o", {31'h0, stall_o}, 32'h1);
        @(posedge CLK); #1;
        chk("rmw T+1 stall_o", {31'h0, stall_o}, 32'h1);
        chk("rmw T+1 ram_we_o", {31'h0, ram_we_o}, 32'h1);
        chk("rmw T+1 ram_addr_o", {22'h0, ram_addr_o}, 32'd8);
        chk("rmw T+1 ram_wdata_o", ram_wdata_o, 32'h0000_0077);
        RST = 1'b0;
        #1;
        chk("mid-rmw reset ram_we_o", {31'h0, ram_we_o}, 32'h0);
        chk("mid-rmw reset stall_o", {31'h0, stall_o}, 32'h0);
        chk("mid-rmw reset err_o", {31'h0, err_o}, 32'h0);
        chk("mid-rmw reset rvalid_o", {31'h0, rvalid_o}, 32'h0);
        chk("mid-rmw reset ram_addr_o", {22'h0, ram_addr_o}, 32'h0);
        chk("mid-rmw reset ram_wdata_o", ram_wdata_o, 32'h0);
        @(posedge CLK); #1;
        we_i = 1'b0; byte_mode_i = 1'b0; addr_i = 32'h0; wdata_i = 32'h0;
        @(posedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        rd_q.push_back(32'h0);
        do_req(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, st);
        chk("post-reset load stalls", st, 0);
        rd_q.push_back(32'h9934_5678);
        do_req(1'b0, 1'b1, 1'b0, 32'h08, 32'h0, st);
        chk("post-reset err_o", {31'h0, err_o}, 32'h0);

`ifdef DMM_MMIO_EN
        begin
            logic [31:0] v1;
            logic [31:0] v2;
            do_req(1'b1, 1'b0, 1'b1, 32'hF000, 32'h5A, st);
            chk("mmio led store stalls", st, 0);
            chk("mmio leds_o", {24'h0, leds_o}, 32'h5A);
            chk("mmio led err_o", {31'h0, err_o}, 32'h0);
            rd_q.push_back(32'h5A);
            do_req(1'b0, 1'b1, 1'b1, 32'hF000, 32'h0, st);
            sb_skip = 1'b1;
            re_i = 1'b1; addr_i = 32'hF004;
            @(posedge CLK); #1;
            re_i = 1'b0; addr_i = 32'h0;
            @(negedge CLK);
            chk("cnt load1 rvalid_o", {31'h0, rvalid_o}, 32'h1);
            v1 = rdata_o;
            repeat (4) @(posedge CLK);
            #1;
            re_i = 1'b1; addr_i = 32'hF004;
            @(posedge CLK); #1;
            re_i = 1'b0; addr_i = 32'h0;
            @(negedge CLK);
            chk("cnt load2 rvalid_o", {31'h0, rvalid_o}, 32'h1);
            v2 = rdata_o;
            sb_skip = 1'b0;
            chk("cnt delta", v2 - v1, 32'd5);
            @(posedge CLK); #1;
            do_req(1'b1, 1'b0, 1'b0, 32'hF004, 32'h1234, st);
            chk("cnt write err_o", {31'h0, err_o}, 32'h1);
            chk("cnt write leds_o", {24'h0, leds_o}, 32'h5A);
        end
`endif

        @(posedge CLK); #1;
        @(posedge CLK); #1;
        chk("pending writes", wr_q.size(), 0);
        chk("pending loads", rd_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/data_mem_manager.md
Name: data_mem_manager

Overview:
- Sits directly downstream of the CPU MEM stage and owns all data-memory traffic.
- Converts CPU byte-addressed word and byte loads/stores into accesses on a word-wide synchronous single-port RAM.
- Performs read-modify-write for byte stores and stalls the pipeline while doing so.
- Returns load data with fixed 1-cycle latency, aligned to the WB stage.

Parameters:
ADDR_W, 10, RAM word-address width (2**ADDR_W words).
MMIO_BASE, 32'h0000_F000, first byte address of the memory-mapped register window.

Ports:
CLK  in  1  clock, rising edge.
RST  in  1  asynchronous, active-low reset.
addr_i  in  32  CPU byte address.
wdata_i  in  32  store data; byte stores use bits [7:0].
we_i  in  1  store request.
re_i  in  1  load request.
byte_mode_i  in  1  1 = byte access, 0 = word access.
rdata_o  out  32  load data; byte loads are zero-extended.
rvalid_o  out  1  rdata_o valid this cycle.
stall_o  out  1  hold the CPU pipeline; combinational.
err_o  out  1  sticky error flag.
ram_addr_o  out  ADDR_W  RAM word address.
ram_wdata_o  out  32  RAM write data.
ram_we_o  out  1  RAM write enable.
ram_rdata_i  in  32  RAM read data, valid one cycle after ram_addr_o.
leds_o  out  8  LED register output.

Behaviour:
- Reset (RST low, asynchronous): state=IDLE; rdata_o=0, rvalid_o=0, stall_o=0, err_o=0, ram_we_o=0, ram_addr_o=0, ram_wdata_o=0, leds_o=0.
- Reset asserted mid-RMW abandons the pending write; no ram_we_o pulse occurs.
- Address decode: word index = addr_i[ADDR_W+1:2]; lane = addr_i[1:0]; little-endian, lane 0 = bits [7:0].
- Any address at or above MMIO_BASE targets MMIO (only when the optional feature is enabled).
- Addresses beyond RAM range and below MMIO_BASE wrap modulo RAM size.
- Word access with lane != 0: aligned down, access still performed, err_o set.
- we_i and re_i both high: treated as a store, err_o set.
- err_o clears only on reset.
- States: IDLE, RMW_WR, DONE.
- IDLE, word store: ram_we_o=1 in the same cycle, ram_wdata_o=wdata_i, no stall; state stays IDLE.
- IDLE, load: ram_addr_o driven in the same cycle. byte_mode_i, lane and the region are registered.
- Load, next cycle: rvalid_o=1 and rdata_o = ram_rdata_i, or {24'b0, selected byte} for byte loads.
- IDLE, byte store to RAM:
  - Cycle T: read issued, stall_o=1; lane, byte and word index captured; go to RMW_WR.
  - Cycle T+1 (RMW_WR): stall_o=1; ram_we_o=1 with ram_rdata_i, the captured lane replaced by the captured byte; go to DONE.
  - Cycle T+2 (DONE): stall_o=0; inputs ignored because the CPU is still presenting the completed request; ram_we_o=0; go to IDLE.
- stall_o = (IDLE and accepted byte store to RAM) or state == RMW_WR.
- rvalid_o is 0 in every cycle that does not follow an accepted load.
- Requests present in RMW_WR or DONE are never re-executed.

Optional Feature:
- Macro DMM_MMIO_EN.
- Defined: MMIO window is active.
  - Offset 0x0: LED register, R/W bits [7:0], drives leds_o.
  - Offset 0x4: 32-bit free-running cycle counter, read-only, increments every cycle, wraps 0xFFFF_FFFF -> 0, resets to 0.
  - MMIO byte stores write directly with no RMW and no stall.
  - MMIO loads use the same 1-cycle latency.
  - Writes to 0x4 or to unmapped offsets are ignored and set err_o.
  - ram_we_o=0 for every MMIO access.
- Undefined: no window; every address maps to RAM modulo size; leds_o tied to 0.

Decomposition:
- Package dmm_pkg holds:
  - state enum dmm_state_t {IDLE, RMW_WR, DONE}
  - MMIO offset constants DMM_LED_OFS, DMM_CNT_OFS
  - lane-merge function
- Sub-module dmm_mmio_regs holds the LED register, cycle counter and read mux; it is instantiated only under DMM_MMIO_EN.

Test Plan:
- Word store then load: store 0xDEADBEEF at 0x10, load 0x10 -> ram_we_o pulse at word 4 with no stall; next load gives rvalid_o=1, rdata_o=0xDEADBEEF one cycle later.
- Byte store RMW: word 4 holds 0x11223344; byte store 0xAA to 0x12 -> stall_o high 2 cycles; ram write 0x11AA3344 at T+1; DONE ignores the held request (exactly one write).
- Byte load: load byte 0x13 from 0x11AA3344 -> rdata_o=0x00000011.
- Error cases: word load at 0x06 -> aligned to word 1 and err_o=1; we_i and re_i both high -> store performed, err_o stays 1 until reset.
- Reset mid-RMW: assert RST low during RMW_WR -> no ram_we_o pulse; all outputs 0 immediately; state IDLE after release.
- With DMM_MMIO_EN: store 0x5A to 0xF000 -> leds_o=0x5A and ram_we_o=0; two loads of 0xF004 N cycles apart -> values differ by N; store to 0xF004 -> err_o=1.
